// File: rtl/fft_reduction.sv
// Radix-conversion stage of the additive FFT over GF(2^GF).
// Rewrites f(x) as f0(x^2+x) + x*f1(x^2+x); even results land in
// coefficient memory A and odd results in memory B, both read through a
// registered port.

module fft_reduction_mem #(
   parameter int W     = 26,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_din,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_dout
);
   logic [W-1:0] mem [0:DEPTH-1];

   // Write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (i_we) mem[i_wr_addr] <= i_din;
   end

   // Registered read port; a same-cycle write returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       o_dout <= '0;
      else if (i_rd_en) o_dout <= mem[i_rd_addr];
   end
endmodule

module fft_reduction #(
   parameter int GF        = 13,
   parameter int NUM_POWER = 6,
   parameter int MEM_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [(GF<<NUM_POWER)-1:0]    coeff_in,
   output logic                          done,
   input  logic                          rd_en,
   input  logic [NUM_POWER-1:0]          rd_addr,
   output logic [MEM_WIDTH*GF-1:0]       mem_coeff_A_dout_0,
   output logic [MEM_WIDTH*GF-1:0]       mem_coeff_B_dout_0
);
   localparam int NUM   = 1 << NUM_POWER;
   localparam int WW    = MEM_WIDTH * GF;
   localparam int DEPTH = NUM / (2 * MEM_WIDTH);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NR    = NUM_POWER - 1;
   localparam int RCW   = $clog2(NUM_POWER);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_WRITE} state_t;

   state_t                     r_state, w_state_next;
   logic [NUM*GF-1:0]          r_c;
   logic [NR-1:0][NUM*GF-1:0]  w_round;
   logic [NUM*GF-1:0]          w_round_sel;
   logic [DEPTH*WW-1:0]        w_a_flat, w_b_flat;
   logic [WW-1:0]              w_a_data, w_b_data;
   logic [AW-1:0]              r_wr_addr;
   logic [RCW-1:0]             round_counter;
   logic                       init_done, round_done;
   logic                       w_load, w_round_en, w_we;
   logic                       w_last_round, w_last_write;
   logic                       w_unused_addr_bits;

   // Every round's result is built in parallel; round_counter picks one.
   genvar gr, gi;
   generate
      for (gr = 0; gr < NR; gr++) begin : g_round
         localparam int K = 1 << (NUM_POWER - 2 - gr);
         for (gi = 0; gi < NUM; gi++) begin : g_coef
            localparam int OFF = gi % (4 * K);
            if (OFF >= 2 * K && OFF < 3 * K) begin : g_mid
               assign w_round[gr][gi*GF +: GF] = r_c[gi*GF +: GF] ^ r_c[(gi+K)*GF +: GF];
            end else if (OFF >= K && OFF < 2 * K) begin : g_low
               assign w_round[gr][gi*GF +: GF] = r_c[gi*GF +: GF] ^ r_c[(gi+K)*GF +: GF]
                                               ^ r_c[(gi+2*K)*GF +: GF];
            end else begin : g_keep
               assign w_round[gr][gi*GF +: GF] = r_c[gi*GF +: GF];
            end
         end
      end
   endgenerate

   // Even coefficients go to A, odd ones to B, MEM_WIDTH lanes per word.
   genvar gw, gj;
   generate
      for (gw = 0; gw < DEPTH; gw++) begin : g_word
         for (gj = 0; gj < MEM_WIDTH; gj++) begin : g_lane
            assign w_a_flat[(gw*MEM_WIDTH+gj)*GF +: GF] = r_c[(2*(gw*MEM_WIDTH+gj))*GF +: GF];
            assign w_b_flat[(gw*MEM_WIDTH+gj)*GF +: GF] = r_c[(2*(gw*MEM_WIDTH+gj)+1)*GF +: GF];
         end
      end
   endgenerate

   assign w_a_data           = w_a_flat[r_wr_addr*WW +: WW];
   assign w_b_data           = w_b_flat[r_wr_addr*WW +: WW];
   assign w_last_round       = (round_counter == RCW'(NR - 1));
   assign w_last_write       = (r_wr_addr == AW'(DEPTH - 1));
   assign w_unused_addr_bits = ^rd_addr;

   // Select the current round's result.
   always_comb begin
      w_round_sel = w_round[0];
      for (int r = 0; r < NR; r++) begin
         if (round_counter == RCW'(r)) w_round_sel = w_round[r];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next-state logic; start is only looked at in IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)        w_state_next = S_ROUND;
         S_ROUND: if (w_last_round) w_state_next = S_WRITE;
         S_WRITE: if (w_last_write) w_state_next = S_IDLE;
         default:                   w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      w_load     = (r_state == S_IDLE) && start;
      w_round_en = (r_state == S_ROUND);
      w_we       = (r_state == S_WRITE);
   end

   // Working coefficient array: loaded on start, rewritten once per round.
   always_ff @(posedge clk) begin
      if (w_load)          r_c <= coeff_in;
      else if (w_round_en) r_c <= w_round_sel;
   end

   // Counters and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_counter <= '0;
         r_wr_addr     <= '0;
         init_done     <= 1'b0;
         round_done    <= 1'b0;
         done          <= 1'b0;
      end else begin
         init_done  <= w_load;
         round_done <= w_round_en;
         done       <= w_we && w_last_write;
         if (w_load)          round_counter <= '0;
         else if (w_round_en) round_counter <= round_counter + 1'b1;
         if (w_load)          r_wr_addr <= '0;
         else if (w_we)       r_wr_addr <= w_last_write ? '0 : r_wr_addr + 1'b1;
      end
   end

   fft_reduction_mem #(.W(WW), .DEPTH(DEPTH), .AW(AW)) mem_coeff_A (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we),
      .i_wr_addr (r_wr_addr),
      .i_din     (w_a_data),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr[AW-1:0]),
      .o_dout    (mem_coeff_A_dout_0)
   );

   fft_reduction_mem #(.W(WW), .DEPTH(DEPTH), .AW(AW)) mem_coeff_B (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we),
      .i_wr_addr (r_wr_addr),
      .i_din     (w_b_data),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr[AW-1:0]),
      .o_dout    (mem_coeff_B_dout_0)
   );
endmodule

// File: tb/tb_fft_reduction.sv
// Bench for fft_reduction: table-driven known polynomials, random
// polynomials against a sequential software model, linearity, back-to-back
// start, read port behaviour and mid-run reset.

module tb_fft_reduction;
   localparam int GF    = 13;
   localparam int NP    = 6;
   localparam int MW    = 2;
   localparam int NUM   = 1 << NP;
   localparam int WW    = MW * GF;
   localparam int DEPTH = NUM / (2 * MW);
   localparam int LAT   = NP + DEPTH - 1;
   localparam int VW    = DEPTH * WW;

   typedef logic [VW-1:0]     vec_t;
   typedef logic [NUM*GF-1:0] poly_t;

   typedef struct packed {
      vec_t        a;
      vec_t        b;
      int unsigned dc;
   } exp_t;

   typedef struct packed {
      poly_t         coeff;
      logic [WW-1:0] a0;
      logic [WW-1:0] b0;
   } tvec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   poly_t          coeff_in = '0;
   logic           rd_en = 1'b0;
   logic [NP-1:0]  rd_addr = '0;
   logic           done;
   logic [WW-1:0]  dout_a, dout_b;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   fft_reduction #(.GF(GF), .NUM_POWER(NP), .MEM_WIDTH(MW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .coeff_in           (coeff_in),
      .done               (done),
      .rd_en              (rd_en),
      .rd_addr            (rd_addr),
      .mem_coeff_A_dout_0 (dout_a),
      .mem_coeff_B_dout_0 (dout_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input vec_t act, input vec_t req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic vec_t snap_a();
      vec_t s;
      for (int w = 0; w < DEPTH; w++) s[w*WW +: WW] = dut.mem_coeff_A.mem[w];
      return s;
   endfunction

   function automatic vec_t snap_b();
      vec_t s;
      for (int w = 0; w < DEPTH; w++) s[w*WW +: WW] = dut.mem_coeff_B.mem[w];
      return s;
   endfunction

   // Sequential form of the reduction: c[i-k] ^= c[i], i = 4k-1 .. 2k per block.
   function automatic exp_t model(input poly_t f);
      logic [GF-1:0] c [NUM];
      exp_t e;
      for (int i = 0; i < NUM; i++) c[i] = f[i*GF +: GF];
      for (int r = 0; r < NP - 1; r++) begin
         int k = 1 << (NP - 2 - r);
         for (int base = 0; base < NUM; base += 4 * k)
            for (int i = 4 * k - 1; i >= 2 * k; i--)
               c[base+i-k] = c[base+i-k] ^ c[base+i];
      end
      e = '0;
      for (int n = 0; n < NUM / 2; n++) begin
         e.a[n*GF +: GF] = c[2*n];
         e.b[n*GF +: GF] = c[2*n+1];
      end
      return e;
   endfunction

   function automatic poly_t rand_poly();
      poly_t v;
      for (int i = 0; i < NUM * GF / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic poly_t one_at(input int idx);
      poly_t v = '0;
      v[idx*GF] = 1'b1;
      return v;
   endfunction

   // Caller is just past a negedge; start is sampled on the next posedge.
   task automatic start_op(input poly_t f, input vec_t ea, input vec_t eb);
      exp_t e;
      coeff_in = f;
      start    = 1'b1;
      e.a  = ea;
      e.b  = eb;
      e.dc = 32'(cyc + 1 + LAT);
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic model_op(input poly_t f);
      exp_t m = model(f);
      start_op(f, m.a, m.b);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   // Scoreboard: every done pulse pops one expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = sb_q.pop_front();
               chk("latency", vec_t'(cyc), vec_t'(e.dc));
               chk("mem_A", snap_a(), e.a);
               chk("mem_B", snap_b(), e.b);
               $display("op complete at cycle %0d, %0d pending", cyc, sb_q.size());
            end
         end
      end
   end

   // Watches init_done / round_done / round_counter through a random run.
   task automatic watch_op(input poly_t f);
      int ni = 0, nr = 0, first = -1, last = -1;
      bit fin = 1'b0;
      model_op(f);
      for (int t = 0; t < 40 && !fin; t++) begin
         if (init_done_probe()) ni++;
         if (dut.round_done) begin
            nr++;
            chk("round_counter", vec_t'(dut.round_counter), vec_t'(nr));
            if (first < 0) first = t;
            last = t;
         end
         if (done) fin = 1'b1;
         else @(negedge clk);
      end
      chk("watch_done", vec_t'(fin), vec_t'(1));
      chk("init_pulses", vec_t'(ni), vec_t'(1));
      chk("round_pulses", vec_t'(nr), vec_t'(NP - 1));
      chk("round_first", vec_t'(first), vec_t'(1));
      chk("round_span", vec_t'(last - first), vec_t'(NP - 2));
      $display("watched run: init=%0d rounds=%0d", ni, nr);
   endtask

   function automatic logic init_done_probe();
      return dut.init_done;
   endfunction

   initial begin : stim
      tvec_t tbl [4];
      poly_t f, g, h;
      vec_t  sfa, sfb, sga, sgb, sha, shb;
      exp_t  m;
      int    nd;

      tbl[0] = '{coeff: one_at(0), a0: WW'(1),       b0: WW'(0)};
      tbl[1] = '{coeff: one_at(1), a0: WW'(0),       b0: WW'(1)};
      tbl[2] = '{coeff: one_at(2), a0: WW'(1) << GF, b0: WW'(1)};
      tbl[3] = '{coeff: one_at(3), a0: WW'(1) << GF, b0: (WW'(1) << GF) | WW'(1)};

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_done", vec_t'(done), '0);
      chk("rst_flags", vec_t'({dut.init_done, dut.round_done}), '0);
      chk("rst_round_counter", vec_t'(dut.round_counter), '0);
      chk("rst_dout", vec_t'({dout_a, dout_b}), '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Known polynomials.
      for (int i = 0; i < 4; i++) begin
         start_op(tbl[i].coeff, vec_t'(tbl[i].a0), vec_t'(tbl[i].b0));
         wait_done();
      end

      // Random polynomials with pulse monitoring.
      for (int s = 0; s < 3; s++) begin
         watch_op(rand_poly());
         @(negedge clk);
      end

      // Linearity across three runs.
      f = rand_poly();
      g = rand_poly();
      model_op(f);     wait_done(); sfa = snap_a(); sfb = snap_b();
      model_op(g);     wait_done(); sga = snap_a(); sgb = snap_b();
      model_op(f ^ g); wait_done(); sha = snap_a(); shb = snap_b();
      chk("lin_A", sha, sfa ^ sga);
      chk("lin_B", shb, sfb ^ sgb);

      // Back-to-back: second start on the done cycle.
      model_op(rand_poly());
      wait_done();
      h = rand_poly();
      m = model(h);
      model_op(h);
      wait_done();

      // Read port against the last run.
      @(negedge clk);
      rd_en = 1'b1; rd_addr = NP'(3);
      @(negedge clk);
      chk("rd_A_w3", vec_t'(dout_a), vec_t'(m.a[3*WW +: WW]));
      chk("rd_B_w3", vec_t'(dout_b), vec_t'(m.b[3*WW +: WW]));
      rd_en = 1'b0; rd_addr = NP'(5);
      @(negedge clk);
      chk("rd_hold", vec_t'(dout_a), vec_t'(m.a[3*WW +: WW]));
      rd_en = 1'b1;
      @(negedge clk);
      chk("rd_A_w5", vec_t'(dout_a), vec_t'(m.a[5*WW +: WW]));
      rd_addr = 6'b110011;
      @(negedge clk);
      chk("rd_upper_A", vec_t'(dout_a), vec_t'(m.a[3*WW +: WW]));
      chk("rd_upper_B", vec_t'(dout_b), vec_t'(m.b[3*WW +: WW]));
      rd_en = 1'b0;

      // Reset in the middle of the rounds.
      model_op(rand_poly());
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("midrst_state", vec_t'(dut.r_state), '0);
      chk("midrst_outputs", vec_t'({done, dout_a, dout_b}), '0);
      chk("midrst_counter", vec_t'(dut.round_counter), '0);
      rst_n = 1'b1;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("midrst_no_done", vec_t'(nd), '0);
      model_op(rand_poly());
      wait_done();

      repeat (3) @(negedge clk);
      chk("sb_empty", vec_t'(sb_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
